// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I LOAD/STORE funct3 codes and the lsu_ctrl state encoding.
package rv32i_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, ACCESS, SPLIT, RESP, FAULT} lsu_state_t;
endpackage

// File: rtl/lsu_align_check.sv
// lsu_align_check: decodes legality, misalignment and access size in bytes from funct3 and addr[1:0].
module lsu_align_check
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_store,
  input  logic [1:0] addr_lo,
  output logic       illegal,
  output logic       misaligned,
  output logic [2:0] nbytes
);
  logic [1:0] sz;
  assign sz         = funct3[1:0];
  assign illegal    = (sz == 2'b11) | (funct3[2] & (is_store | funct3[1]));
  assign misaligned = (sz == F3_H[1:0] & addr_lo[0]) | (sz == F3_W[1:0] & |addr_lo);
  assign nbytes     = sz == F3_W[1:0] ? 3'd4 : sz == F3_H[1:0] ? 3'd2 : 3'd1;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between execute and data memory; LSU_MISALIGN_SPLIT_EN splits misaligned accesses into bytes.
module lsu_ctrl
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_fault,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data
);
  lsu_state_t state, state_nx;
  logic [2:0]  f3_q;
  logic        st_q, fault_q;
  logic [31:0] addr_q, wdata_q, rdata_q, load_d;
  logic        illegal, misaligned, accept, active, split;
  logic [2:0]  nbytes;
  logic [1:0]  ofs;
  lsu_align_check u_chk (
    .funct3    (req_funct3),
    .is_store  (req_is_store),
    .addr_lo   (req_addr[1:0]),
    .illegal   (illegal),
    .misaligned(misaligned),
    .nbytes    (nbytes)
  );
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
  logic [1:0]  cnt;
  logic [2:0]  n_q;
  logic        last;
  logic [31:0] asm_d;
  assign split = state == SPLIT;
  assign ofs   = cnt;
  assign last  = {1'b0, cnt} == n_q - 3'd1;
  always_comb begin
    asm_d = rdata_q;
    asm_d[{cnt, 3'b000} +: 8] = mem_read_data[7:0];
  end
  // Sign extension is applied only once the final byte of the halfword has landed.
  assign load_d = !split ? mem_read_data :
                  (last && f3_q == F3_H) ? {{16{asm_d[15]}}, asm_d[15:0]} : asm_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      n_q <= '0;
    end else if (accept) begin
      cnt <= '0;
      n_q <= nbytes;
    end else if (split) cnt <= cnt + 2'd1;
`else
  localparam bit SPLIT_EN = 1'b0;
  logic unused_nbytes;
  assign unused_nbytes = ^nbytes;
  assign split  = 1'b0;
  assign ofs    = 2'd0;
  assign load_d = mem_read_data;
`endif
  localparam lsu_state_t MIS_ST = SPLIT_EN ? SPLIT : FAULT;
  assign accept = req_valid & req_ready;
  assign active = state == ACCESS | split;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:          if (accept) state_nx = illegal ? FAULT : misaligned ? MIS_ST : ACCESS;
      ACCESS, FAULT: state_nx = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
      SPLIT:         if (last) state_nx = RESP;
`endif
      default:       state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      f3_q    <= '0;
      st_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      f3_q    <= req_funct3;
      st_q    <= req_is_store;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
      fault_q <= illegal | (misaligned & ~SPLIT_EN);
    end else if (active & ~st_q) rdata_q <= load_d;
  // Memory-side outputs are held at zero outside access cycles, so reset drops them at once.
  assign req_ready      = state == IDLE;
  assign mem_read_en    = active & ~st_q;
  assign mem_write_en   = active & st_q;
  assign mem_address    = active ? addr_q + {30'd0, ofs} : '0;
  assign mem_funct3     = !active ? 3'b000 : split ? (st_q ? F3_B : F3_BU) : f3_q;
  assign mem_write_data = !active ? '0 : split ? {24'd0, wdata_q[{ofs, 3'b000} +: 8]} : wdata_q;
  assign rsp_valid      = state == RESP;
  assign rsp_data       = rsp_valid ? rdata_q : '0;
  assign rsp_fault      = rsp_valid & fault_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized bench for lsu_ctrl against a byte-level memory model; follows LSU_MISALIGN_SPLIT_EN.
module tb_lsu_ctrl;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault, mem_read_en, mem_write_en;
  logic [31:0] rsp_data, mem_address, mem_write_data, mem_read_data;
  logic [2:0]  mem_funct3;
  logic [7:0]  mem [64];
  logic [7:0]  ref_mem [64];
  logic        mem_clr = 1'b1, pre_en = 1'b0;
  logic [5:0]  pre_a, ma;
  logic [31:0] pre_w, mw, last_d;
  logic        last_f;
  realtime     accept_t;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_funct3(mem_funct3), .mem_read_data(mem_read_data)
  );

  function automatic int nb(input logic [2:0] f3);
    return f3[1:0] == 2'b10 ? 4 : f3[1:0] == 2'b01 ? 2 : 1;
  endfunction

  // 64-byte memory, wrapping: aligned accesses return the RV32I-extended value.
  always_comb begin
    ma = mem_address[5:0];
    mw = {mem[ma + 6'd3], mem[ma + 6'd2], mem[ma + 6'd1], mem[ma]};
    mem_read_data = mem_funct3 == 3'b000 ? {{24{mw[7]}}, mw[7:0]} :
                    mem_funct3 == 3'b001 ? {{16{mw[15]}}, mw[15:0]} :
                    mem_funct3 == 3'b100 ? {24'd0, mw[7:0]} :
                    mem_funct3 == 3'b101 ? {16'd0, mw[15:0]} : mw;
  end

  always @(posedge clk) begin
    if (mem_clr) for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    else if (pre_en) for (int k = 0; k < 4; k++) mem[6'(pre_a + 6'(k))] <= pre_w[8*k +: 8];
    else if (mem_write_en) for (int k = 0; k < nb(mem_funct3); k++) mem[6'(ma + 6'(k))] <= mem_write_data[8*k +: 8];
  end

  task automatic preload(input logic [5:0] a, input logic [31:0] w);
    @(negedge clk);
    pre_en = 1'b1; pre_a = a; pre_w = w;
    for (int k = 0; k < 4; k++) ref_mem[6'(a + 6'(k))] = w[8*k +: 8];
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    n_tests++;
    if ({req_ready, rsp_valid, rsp_data, rsp_fault, mem_read_en, mem_write_en, mem_address, mem_write_data, mem_funct3}
        !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL %s: ready=%b rsp_v=%b data=%h fault=%b rd=%b wr=%b addr=%h wd=%h f3=%b, required ready=1 and all else 0",
               name, req_ready, rsp_valid, rsp_data, rsp_fault, mem_read_en, mem_write_en, mem_address, mem_write_data, mem_funct3);
    end
  endtask

  // One request, compared against what the access rules say it must do.
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input string name);
    bit legal, mis, flt, spl, got_f;
    int n, exp_lat, exp_en, lat, en_rd, en_wr, bus_bad, w;
    logic [31:0] exp_d, got_d, t;
    n     = nb(f3);
    legal = st ? (f3 inside {3'b000, 3'b001, 3'b010}) : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    mis   = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
    flt   = !legal || (mis && !SPLIT_EN);
    spl   = !flt && mis;
    exp_d = '0;
    if (!flt) begin
      for (int k = 0; k < n; k++) begin
        t = a + 32'(k);
        if (st) ref_mem[t[5:0]] = wd[8*k +: 8];
        else exp_d[8*k +: 8] = ref_mem[t[5:0]];
      end
      if (!st && f3 == 3'b000) exp_d = {{24{exp_d[7]}}, exp_d[7:0]};
      if (!st && f3 == 3'b001) exp_d = {{16{exp_d[15]}}, exp_d[15:0]};
    end
    exp_lat = spl ? n + 1 : 2;
    exp_en  = flt ? 0 : spl ? n : 1;
    w = 0;
    while (!req_ready && w < 10) begin @(negedge clk); w++; end
    n_tests++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL %s ready: req_ready=0 after 10 cycles, required 1", name);
      return;
    end
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    accept_t = $realtime;
    #1 req_valid = 1'b0;
    lat = 0; en_rd = 0; en_wr = 0; bus_bad = 0; got_d = '0; got_f = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1 && req_ready !== 1'b0) bus_bad++;
      if (mem_read_en || mem_write_en) begin
        if (mem_address !== a + (spl ? 32'(en_rd + en_wr) : 32'd0)) bus_bad++;
        if (mem_funct3 !== (spl ? (st ? 3'b000 : 3'b100) : f3)) bus_bad++;
        if (mem_read_en) en_rd++;
        if (mem_write_en) en_wr++;
      end
      if (rsp_valid) begin lat = c; got_d = rsp_data; got_f = rsp_fault; break; end
    end
    last_d = got_d; last_f = got_f;
    n_tests += 5;
    if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, exp_lat); end
    if (got_d !== exp_d) begin n_fail++; $display("FAIL %s rsp_data: got %h, required %h", name, got_d, exp_d); end
    if (got_f !== flt) begin n_fail++; $display("FAIL %s rsp_fault: got %b, required %b", name, got_f, flt); end
    if (en_rd != (st ? 0 : exp_en) || en_wr != (st ? exp_en : 0)) begin
      n_fail++;
      $display("FAIL %s enables: rd=%0d wr=%0d cycles, required rd=%0d wr=%0d", name, en_rd, en_wr, st ? 0 : exp_en, st ? exp_en : 0);
    end
    if (bus_bad != 0) begin n_fail++; $display("FAIL %s bus: %0d bad address/funct3/ready samples, required 0", name, bus_bad); end
  endtask

  task automatic expect_const(input string name, input logic [31:0] d, input logic f);
    n_tests++;
    if (last_d !== d || last_f !== f) begin
      n_fail++;
      $display("FAIL %s: got data=%h fault=%b, required data=%h fault=%b", name, last_d, last_f, d, f);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_directed;
    preload(6'd0, 32'hAABBCCDD);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, "lw0");
    expect_const("lw0_value", 32'hAABBCCDD, 1'b0);
    do_req(1'b1, 3'b000, 32'h5, 32'h11, "sb5");
    do_req(1'b0, 3'b100, 32'h5, 32'h0, "lbu5");
    expect_const("lbu5_value", 32'h00000011, 1'b0);
    do_req(1'b0, 3'b000, 32'h4, 32'h0, "lb4");
    do_req(1'b0, 3'b001, 32'h1, 32'h0, "lh1");
    do_req(1'b0, 3'b011, 32'h0, 32'h0, "ld011");
    expect_const("ld011_fault", 32'h0, 1'b1);
    do_req(1'b1, 3'b100, 32'h8, 32'h12345678, "st100");
`ifdef LSU_MISALIGN_SPLIT_EN
    preload(6'd0, 32'hAABBCCDD);
    preload(6'd4, 32'h11223344);
    do_req(1'b0, 3'b010, 32'h2, 32'h0, "lw2_split");
    expect_const("lw2_value", 32'h3344AABB, 1'b0);
    do_req(1'b0, 3'b001, 32'h3, 32'h0, "lh3_split");
    expect_const("lh3_value", 32'h000044AA, 1'b0);
    do_req(1'b1, 3'b010, 32'h1, 32'hDEADBEEF, "sw1_split");
    do_req(1'b0, 3'b010, 32'h0, 32'h0, "lw0_after_split");
    expect_const("lw0_after_split_value", 32'hADBEEFDD, 1'b0);
    do_req(1'b0, 3'b100, 32'h4, 32'h0, "lbu4_after_split");
    expect_const("lbu4_value", 32'h000000DE, 1'b0);
`else
    expect_const("lh1_fault", 32'h0, 1'b1);
`endif
  endtask

  task automatic test_back_to_back;
    realtime prev;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 3'b010, 32'($urandom_range(0, 15)) << 2, 32'h0, "b2b_lw");
      if (i > 0) begin
        n_tests++;
        if (accept_t - prev != 30.0) begin
          n_fail++;
          $display("FAIL b2b_throughput: accept spacing %0t, required 30", accept_t - prev);
        end
      end
      prev = accept_t;
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, "random");
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_wdata = 32'hDEADBEEF;
    req_addr = SPLIT_EN ? 32'h1 : 32'h8;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (SPLIT_EN ? 3 : 1) @(negedge clk);
    n_tests++;
    if (mem_write_en !== 1'b1) begin n_fail++; $display("FAIL mid_write_active: mem_write_en=%b, required 1", mem_write_en); end
    if (SPLIT_EN) begin ref_mem[1] = 8'hEF; ref_mem[2] = 8'hBE; end
    rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outputs("after_mid_reset");
    do_req(1'b0, 3'b010, 32'h0, 32'h0, "lw_after_reset");
  endtask

  task automatic test_mem;
    int bad;
    bad = 0;
    @(negedge clk);
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL memory_image: %0d bytes differ, required 0", bad); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_random;
    test_reset_mid;
    test_mem;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
